// File: rtl/layer_scheduler.sv
// Epoch sequencer for a Neuron layer chain: drives iMode and admits exactly NB tokens per phase.
// Optional status outputs (epoch, admitted count, busy cycle count) under LAYER_SCHEDULER_STATUS_EN.
module layer_scheduler #(
    parameter int NB = 8,
    parameter int NE = 4,
    parameter int WD = 16,
    localparam int CW = $clog2(NB + 1),
    localparam int EW = (NE > 1) ? $clog2(NE) : 1
) (
    input  logic          iCLK,
    input  logic          iRST,
    input  logic          iStart,
    output logic          oMode,
    input  logic          iValid_AS_Input,
    output logic          oReady_AS_Input,
    input  logic [WD-1:0] iData_AS_Input,
    output logic          oValid_BM_Input,
    input  logic          iReady_BM_Input,
    output logic [WD-1:0] oData_BM_Input,
    input  logic          iValid_AS_Delta,
    output logic          oReady_AS_Delta,
    input  logic [WD-1:0] iData_AS_Delta,
    output logic          oValid_BM_Delta,
    input  logic          iReady_BM_Delta,
    output logic [WD-1:0] oData_BM_Delta,
    input  logic          iRetire,
`ifdef LAYER_SCHEDULER_STATUS_EN
    output logic [EW-1:0] oEpoch,
    output logic [CW-1:0] oAdmitted,
    output logic [31:0]   oCycles,
`endif
    output logic          oBusy,
    output logic          oDone,
    output logic          oError
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FWD  = 2'd1,
        BWD  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [CW-1:0] NB_C   = CW'(NB);
    localparam logic [EW-1:0] LAST_E = EW'(NE - 1);

    state_t        state, state_nxt;
    logic [CW-1:0] adm, adm_nxt;
    logic [CW-1:0] outs, outs_nxt;
    logic [CW-1:0] ret, ret_nxt;
    logic [EW-1:0] ep, ep_nxt;
    logic          mode, mode_nxt;
    logic          error, error_nxt;
    logic          open_f, open_b;
    logic          admit, retire_ok;

    assign open_f = (state == FWD) && (adm < NB_C);
    assign open_b = (state == BWD) && (adm < NB_C);

    assign oValid_BM_Input = iValid_AS_Input & open_f;
    assign oReady_AS_Input = iReady_BM_Input & open_f;
    assign oData_BM_Input  = iData_AS_Input;
    assign oValid_BM_Delta = iValid_AS_Delta & open_b;
    assign oReady_AS_Delta = iReady_BM_Delta & open_b;
    assign oData_BM_Delta  = iData_AS_Delta;

    assign admit = (iValid_AS_Input & iReady_BM_Input & open_f) |
                   (iValid_AS_Delta & iReady_BM_Delta & open_b);

    // A retire only counts when a phase is active and something is actually in flight.
    assign retire_ok = iRetire && ((state == FWD) || (state == BWD)) && (outs != '0);

    assign oMode  = mode;
    assign oBusy  = (state != IDLE);
    assign oDone  = (state == DONE);
    assign oError = error;

    // NOTE: every variable gets a default at the top of the block so no path leaves it unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        state_nxt = state;
        adm_nxt   = admit ? adm + 1'b1 : adm;
        ret_nxt   = retire_ok ? ret + 1'b1 : ret;
        outs_nxt  = outs;
        ep_nxt    = ep;
        mode_nxt  = mode;
        error_nxt = error | (iRetire & ~retire_ok);

        if (admit && !retire_ok)      outs_nxt = outs + 1'b1;
        else if (!admit && retire_ok) outs_nxt = outs - 1'b1;

        // Phase ends on the edge that registers the last retire, so the new mode appears next cycle.
        unique case (state)
            IDLE: begin
                mode_nxt = 1'b0;
                if (iStart) begin
                    state_nxt = FWD;
                    adm_nxt   = '0;
                    ret_nxt   = '0;
                    outs_nxt  = '0;
                    ep_nxt    = '0;
                end
            end
            FWD: begin
                if (ret_nxt == NB_C) begin
                    state_nxt = BWD;
                    mode_nxt  = 1'b1;
                    adm_nxt   = '0;
                    ret_nxt   = '0;
                end
            end
            BWD: begin
                if (ret_nxt == NB_C) begin
                    mode_nxt = 1'b0;
                    adm_nxt  = '0;
                    ret_nxt  = '0;
                    if (ep == LAST_E) begin
                        state_nxt = DONE;
                    end else begin
                        state_nxt = FWD;
                        ep_nxt    = ep + 1'b1;
                    end
                end
            end
            DONE: begin
                state_nxt = IDLE;
                mode_nxt  = 1'b0;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together
    // from pre-edge values, independent of statement order.
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state <= IDLE;
            adm   <= '0;
            outs  <= '0;
            ret   <= '0;
            ep    <= '0;
            mode  <= 1'b0;
            error <= 1'b0;
        end else begin
            state <= state_nxt;
            adm   <= adm_nxt;
            outs  <= outs_nxt;
            ret   <= ret_nxt;
            ep    <= ep_nxt;
            mode  <= mode_nxt;
            error <= error_nxt;
        end
    end

`ifdef LAYER_SCHEDULER_STATUS_EN
    logic [31:0] cycles;

    // Counts every busy cycle including DONE; restarts on the edge that leaves IDLE.
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            cycles <= '0;
        end else if (state == IDLE) begin
            if (iStart) cycles <= '0;
        end else if (cycles != 32'hFFFF_FFFF) begin
            cycles <= cycles + 32'd1;
        end
    end

    assign oEpoch    = ep;
    assign oAdmitted = adm;
    assign oCycles   = cycles;
`endif

endmodule

// File: tb/tb_layer_scheduler.sv
// Scoreboard bench for layer_scheduler (NB=4, NE=3): driver pushes expected tokens, monitor pops on each admit.
// Also checks mode-switch latency, DONE pulse, backpressure, reset abort and sticky error.
module tb_layer_scheduler;

    localparam int NB = 4;
    localparam int NE = 3;
    localparam int WD = 16;
    localparam int CW = $clog2(NB + 1);
    localparam int EW = (NE > 1) ? $clog2(NE) : 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          in_valid, net_in_ready;
    logic [WD-1:0] in_data;
    logic          dl_valid, net_dl_ready;
    logic [WD-1:0] dl_data;
    logic          man_ret, auto_ret, auto_en;
    logic          retire;

    logic          mode, rdy_in, vld_in, rdy_dl, vld_dl, busy, done, err;
    logic [WD-1:0] dat_in, dat_dl;
`ifdef LAYER_SCHEDULER_STATUS_EN
    logic [EW-1:0] epoch;
    logic [CW-1:0] admitted;
    logic [31:0]   cycles;
`endif

    int tests  = 0;
    int failed = 0;
    int cyc = 0;
    int last_ret_cyc = -10;
    int done_cnt = 0;
    logic [WD-1:0] exp_in[$];
    logic [WD-1:0] exp_dl[$];

    assign retire = man_ret | auto_ret;

    always #5 clk = ~clk;

    layer_scheduler #(.NB(NB), .NE(NE), .WD(WD)) dut (
        .iCLK(clk), .iRST(rst), .iStart(start), .oMode(mode),
        .iValid_AS_Input(in_valid), .oReady_AS_Input(rdy_in), .iData_AS_Input(in_data),
        .oValid_BM_Input(vld_in), .iReady_BM_Input(net_in_ready), .oData_BM_Input(dat_in),
        .iValid_AS_Delta(dl_valid), .oReady_AS_Delta(rdy_dl), .iData_AS_Delta(dl_data),
        .oValid_BM_Delta(vld_dl), .iReady_BM_Delta(net_dl_ready), .oData_BM_Delta(dat_dl),
        .iRetire(retire),
`ifdef LAYER_SCHEDULER_STATUS_EN
        .oEpoch(epoch), .oAdmitted(admitted), .oCycles(cycles),
`endif
        .oBusy(busy), .oDone(done), .oError(err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail(input string name);
        tests++;
        failed++;
        $display("FAIL %s: bound expired or unexpected event (t=%0t)", name, $time);
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Network model: each admitted token retires two cycles after admission.
    initial begin
        logic [1:0] h;
        h = '0;
        auto_ret = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) h = '0;
            auto_ret = h[1] & auto_en;
            h = {h[0], 1'b0};
            #2;
            if (auto_en && ((vld_in && net_in_ready) || (vld_dl && net_dl_ready))) h[0] = 1'b1;
        end
    end

    // Monitor: pops the scoreboard on every admit and checks phase timing.
    initial begin
        logic          prev_mode, prev_done, prev_busy;
        logic [WD-1:0] e;
        int            busy_cnt;
        prev_mode = 1'b0; prev_done = 1'b0; prev_busy = 1'b0; busy_cnt = 0;
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                prev_mode = mode; prev_done = 1'b0; prev_busy = 1'b0;
            end else begin
                if (vld_in && net_in_ready) begin
                    if (exp_in.size() == 0) fail("input_unexpected_admit");
                    else begin
                        e = exp_in.pop_front();
                        check("input_data", 32'(dat_in), 32'(e));
                        check("input_mode", 32'(mode), 32'd0);
                    end
                end
                if (vld_dl && net_dl_ready) begin
                    if (exp_dl.size() == 0) fail("delta_unexpected_admit");
                    else begin
                        e = exp_dl.pop_front();
                        check("delta_data", 32'(dat_dl), 32'(e));
                        check("delta_mode", 32'(mode), 32'd1);
                    end
                end
                if (mode != prev_mode) check("mode_switch_latency", 32'(cyc), 32'(last_ret_cyc + 1));
                if (done) begin
                    check("done_single_pulse", 32'(prev_done), 32'd0);
                    check("done_busy", 32'(busy), 32'd1);
                    done_cnt++;
`ifdef LAYER_SCHEDULER_STATUS_EN
                    check("epoch_at_done", 32'(epoch), 32'(NE - 1));
`endif
                end
                if (busy && !prev_busy) busy_cnt = 1;
                else if (busy) busy_cnt++;
`ifdef LAYER_SCHEDULER_STATUS_EN
                if (!busy && prev_busy) check("cycles_busy", cycles, 32'(busy_cnt));
`endif
                prev_mode = mode;
                prev_done = done;
                prev_busy = busy;
            end
            if (retire) last_ret_cyc = cyc;
        end
    end

    // Presents n samples starting at base; returns on the negedge after the last one is accepted.
    task automatic send_in(input int n, input logic [WD-1:0] base);
        for (int i = 0; i < n; i++) begin
            int t = 0;
            in_data  = base + WD'(i);
            in_valid = 1'b1;
            exp_in.push_back(base + WD'(i));
            #1;
            while (!rdy_in && t < 200) begin
                @(negedge clk); #1; t++;
            end
            if (t >= 200) fail("send_input_timeout");
            @(negedge clk);
        end
    endtask

    task automatic send_dl(input int n, input logic [WD-1:0] base);
        for (int i = 0; i < n; i++) begin
            int t = 0;
            dl_data  = base + WD'(i);
            dl_valid = 1'b1;
            exp_dl.push_back(base + WD'(i));
            #1;
            while (!rdy_dl && t < 200) begin
                @(negedge clk); #1; t++;
            end
            if (t >= 200) fail("send_delta_timeout");
            @(negedge clk);
        end
    endtask

    task automatic wait_mode(input logic v);
        int t = 0;
        while (mode !== v && t < 100) begin
            @(negedge clk); #1; t++;
        end
        if (t >= 100) fail("wait_mode_timeout");
        @(negedge clk);
    endtask

    task automatic wait_done();
        int t = 0;
        while (done !== 1'b1 && t < 200) begin
            @(negedge clk); #1; t++;
        end
        if (t >= 200) fail("wait_done_timeout");
    endtask

    task automatic run_fwd(input logic [WD-1:0] base);
        send_in(NB, base);
        #1;
        check("input_gate_closed_ready", 32'(rdy_in), 32'd0);
        check("input_gate_closed_valid", 32'(vld_in), 32'd0);
        in_valid = 1'b0;
        wait_mode(1'b1);
    endtask

    task automatic run_bwd(input logic [WD-1:0] base, input bit last);
        send_dl(NB, base);
        #1;
        check("delta_gate_closed_ready", 32'(rdy_dl), 32'd0);
        check("delta_gate_closed_valid", 32'(vld_dl), 32'd0);
        dl_valid = 1'b0;
        if (!last) wait_mode(1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests + 1, failed + 1);
        $fatal(1);
    end

    initial begin
        rst = 1'b1; start = 1'b0; man_ret = 1'b0; auto_en = 1'b0;
        in_valid = 1'b0; in_data = '0; net_in_ready = 1'b0;
        dl_valid = 1'b0; dl_data = '0; net_dl_ready = 1'b0;
        repeat (2) @(negedge clk);

        in_valid = 1'b1; dl_valid = 1'b1; net_in_ready = 1'b1; net_dl_ready = 1'b1;
        #1;
        check("rst_mode", 32'(mode), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_error", 32'(err), 0);
        check("rst_in_valid", 32'(vld_in), 0);
        check("rst_in_ready", 32'(rdy_in), 0);
        check("rst_dl_valid", 32'(vld_dl), 0);
        check("rst_dl_ready", 32'(rdy_dl), 0);
        in_valid = 1'b0; dl_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        #1 check("idle_not_busy", 32'(busy), 0);

        // Run A: pulsed start, automatic retires, backpressure at the start of epoch 0.
        @(negedge clk);
        auto_en = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        net_in_ready = 1'b0; in_valid = 1'b1; in_data = 16'h0100;
        for (int i = 0; i < 10; i++) begin
            #1 check("backpressure_ready", 32'(rdy_in), 0);
            @(negedge clk);
        end
`ifdef LAYER_SCHEDULER_STATUS_EN
        #1 check("backpressure_adm", 32'(admitted), 0);
        @(negedge clk);
`endif
        net_in_ready = 1'b1;
        for (int e = 0; e < NE; e++) begin
            run_fwd(16'h0100 + 16'(e * 16));
            run_bwd(16'h0200 + 16'(e * 16), e == NE - 1);
        end
        wait_done();
        @(negedge clk);
        #1 check("busy_falls_after_done", 32'(busy), 0);
        repeat (3) @(negedge clk);
        #1 check("stays_idle", 32'(busy), 0);
        check("done_count_run_a", 32'(done_cnt), 1);
        check("no_error_run_a", 32'(err), 0);

        // Run B: held start, manual retires in epoch 0 FWD with a simultaneous admit+retire.
        @(negedge clk);
        auto_en = 1'b0;
        start = 1'b1;
        @(negedge clk);
        send_in(2, 16'h0300);
        man_ret = 1'b1;
        send_in(1, 16'h0302);
        man_ret = 1'b0;
        in_valid = 1'b0;
`ifdef LAYER_SCHEDULER_STATUS_EN
        #1 check("simul_adm", 32'(admitted), 3);
`endif
        @(negedge clk);
        send_in(1, 16'h0303);
        in_valid = 1'b0;
        repeat (3) begin
            man_ret = 1'b1;
            @(negedge clk);
        end
        man_ret = 1'b0;
        wait_mode(1'b1);
        check("no_error_simul", 32'(err), 0);
        auto_en = 1'b1;
        run_bwd(16'h0400, 1'b0);
        for (int e = 1; e < NE; e++) begin
            run_fwd(16'h0500 + 16'(e * 16));
            run_bwd(16'h0600 + 16'(e * 16), e == NE - 1);
        end
        wait_done();
        @(negedge clk);
        #1 check("restart_idle_gap", 32'(busy), 0);
        @(negedge clk);
        #1 check("restart_busy", 32'(busy), 1);
        start = 1'b0;
        check("done_count_run_b", 32'(done_cnt), 2);

        // Run C: abort with three deltas in flight.
        @(negedge clk);
        run_fwd(16'h0700);
        auto_en = 1'b0;
        send_dl(3, 16'h0800);
        rst = 1'b1;
        #1;
        check("abort_mode", 32'(mode), 0);
        check("abort_busy", 32'(busy), 0);
        check("abort_dl_valid", 32'(vld_dl), 0);
        check("abort_dl_ready", 32'(rdy_dl), 0);
        dl_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        #1 check("after_abort_idle", 32'(busy), 0);

        // Run D: spurious retires in IDLE and in FWD with nothing outstanding.
        @(negedge clk);
        check("pre_spurious_error", 32'(err), 0);
        man_ret = 1'b1;
        @(negedge clk);
        man_ret = 1'b0;
        #1;
        check("spurious_idle_error", 32'(err), 1);
        check("spurious_idle_busy", 32'(busy), 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1 check("error_cleared_by_reset", 32'(err), 0);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        man_ret = 1'b1;
        @(negedge clk);
        man_ret = 1'b0;
        #1 check("spurious_fwd_error", 32'(err), 1);
`ifdef LAYER_SCHEDULER_STATUS_EN
        check("spurious_fwd_adm", 32'(admitted), 0);
`endif
        @(negedge clk);
        auto_en = 1'b1;
        run_fwd(16'h0900);
        check("error_sticky", 32'(err), 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        auto_en = 1'b0;
        #1 check("error_cleared_final", 32'(err), 0);

        check("input_queue_empty", 32'(exp_in.size()), 0);
        check("delta_queue_empty", 32'(exp_dl.size()), 0);
        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/layer_scheduler.md
Name: layer_scheduler

Overview:
- Sequences one training epoch loop for a layer chain built from Neuron blocks.
- Drives the shared iMode line (0 = forward, 1 = backward).
- Gates admission of input samples (forward) and error deltas (backward) so that exactly NB tokens enter per phase.
- Switches mode only once the network has drained, and repeats for NE epochs.

Parameters:
NB  8   samples per batch (tokens admitted per phase), >=1
NE  4   epochs per run, >=1
WD  16  data width of both gated streams (pass-through)

Ports:
iCLK             input   1   clock
iRST             input   1   asynchronous active-high reset
iStart           input   1   level; run begins when sampled high in IDLE
oMode            output  1   mode to all Neuron iMode inputs
iValid_AS_Input  input   1   sample source valid
oReady_AS_Input  output  1   sample source ready
iData_AS_Input   input   WD  sample data
oValid_BM_Input  output  1   to network input valid
iReady_BM_Input  input   1   network input ready
oData_BM_Input   output  WD  sample data, combinational pass-through
iValid_AS_Delta  input   1   delta source valid
oReady_AS_Delta  output  1   delta source ready
iData_AS_Delta   input   WD  delta data
oValid_BM_Delta  output  1   to network delta valid
iReady_BM_Delta  input   1   network delta ready
oData_BM_Delta   output  WD  delta data, pass-through
iRetire          input   1   one-cycle pulse: one token finished leaving the network (output fire in forward, weight-update fire in backward)
oBusy            output  1   state != IDLE
oDone            output  1   one-cycle pulse when run completes
oError           output  1   sticky protocol error

Behaviour:
- Reset (async, iRST=1): state IDLE, counters 0; oMode=0, oBusy=0, oDone=0, oError=0; all gated valid/ready outputs 0.
- Gating (combinational, zero latency):
  - openF = (state==FWD) && (adm<NB); oValid_BM_Input = iValid_AS_Input & openF; oReady_AS_Input = iReady_BM_Input & openF.
  - openB = (state==BWD) && (adm<NB); same rule for the Delta channel.
  - Data always passes straight through.
  - Admit event = iValid_AS & iReady_BM & open.
- Counters:
  - adm: 0..NB, admitted this phase.
  - out: 0..NB, outstanding; +1 on admit, -1 on iRetire; simultaneous admit and retire leaves it unchanged.
  - ret: 0..NB, retired this phase.
  - ep: 0..NE-1, epoch index.
- Retire error: iRetire while out==0, or iRetire in IDLE/DONE, is ignored (no counter change) and sets oError; oError clears only on reset.
- States:
  - IDLE: oMode=0. iStart=1 -> FWD with adm/out/ret/ep cleared.
  - FWD: oMode=0. When ret==NB (adm==NB, out==0) -> BWD at the next edge; adm/ret cleared on entry.
  - BWD: oMode=1. When ret==NB -> if ep==NE-1 go to DONE, else ep+1 and go to FWD; adm/ret cleared.
  - DONE: oDone=1 for exactly this one cycle; oMode=0 -> IDLE. Re-run requires iStart high in IDLE, so a held iStart restarts one cycle after DONE.
- oMode is registered and changes only on FWD<->BWD transitions, when out==0. Neuron never sees a mode change with tokens in flight.
- Latency: the last retire at cycle t puts the new oMode and the new phase's open gate at t+1.
- iStart is ignored outside IDLE.
- Asserting iRST mid-run aborts immediately to the reset state. In-flight tokens are not tracked after reset.
- Counter widths are $clog2(NB+1) and $clog2(NE); no wrap-around is possible, because admission stops at NB.

Optional Feature:
- Macro: LAYER_SCHEDULER_STATUS_EN.
- Defined: adds the following outputs, all 0 at reset; they are held in DONE/IDLE until the next iStart.
  - oEpoch [$clog2(NE)-1:0] = ep.
  - oAdmitted [$clog2(NB+1)-1:0] = adm.
  - oCycles [31:0] = free-running cycle count while oBusy, saturating at 2^32-1.
- Undefined: these ports and their registers are absent; all other behaviour is identical.

Test Plan:
- Reset mid-BWD: assert iRST with out=3 -> same cycle oMode=0, gates closed, oBusy=0; after release the block stays IDLE until iStart.
- NB=4, NE=1, source always valid, network always ready, iRetire 2 cycles after each admit:
  - exactly 4 inputs admitted, then the gate closes;
  - oMode rises the cycle after the 4th retire;
  - 4 deltas admitted, then oDone pulses once and oBusy falls the next cycle.
- Backpressure: iReady_BM_Input low for 10 cycles in FWD -> oReady_AS_Input low; adm unchanged; no admit counted.
- Simultaneous admit and iRetire in the same cycle with out=2 -> out stays 2, adm+1, ret+1.
- Spurious iRetire in IDLE, and in FWD with out=0 -> counters unchanged, oError=1 and stays 1 until reset.
- NE=3, iStart held high -> three FWD/BWD pairs; ep goes 0,1,2; one oDone; a new run starts 1 cycle after DONE.
  - With LAYER_SCHEDULER_STATUS_EN: oEpoch=2 at DONE and oCycles equals the number of cycles oBusy was high.
